// File: rtl/disp_pkg.sv
// Shared widths, codes and digit helpers for the display scanner.
package disp_pkg;

  localparam int unsigned DIGW   = 4;
  localparam int unsigned MAXDIG = 8;
  localparam logic [DIGW-1:0] BLANK_CODE = 4'hF;

  // Extract BCD digit i from a (zero-extended) packed digit vector.
  function automatic logic [DIGW-1:0] dig_slice(input logic [MAXDIG*DIGW-1:0] v,
                                                input int unsigned i);
    return v[DIGW*i +: DIGW];
  endfunction

endpackage

// File: rtl/disp_lzmask.sv
// Leading-zero blank mask: bit i set when digit i and every digit above it is zero.
module disp_lzmask
  import disp_pkg::*;
#(
  parameter int unsigned NDIG = 8,
  parameter bit          LZB  = 1'b1
) (
  input  logic [DIGW*NDIG-1:0] shadow,
  output logic [NDIG-1:0]      mask
);

  logic [MAXDIG*DIGW-1:0] wide;

  assign wide = (MAXDIG*DIGW)'(shadow);

  // Walk from the most significant digit down; digit 0 always stays lit.
  always_comb begin
    logic z;
    mask = '0;
    z    = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      z       = z && (dig_slice(wide, i) == '0);
      mask[i] = LZB && (i != 0) && z;
    end
  end

endmodule

// File: rtl/disp_scan.sv
// Double-buffered, leading-zero-blanked multiplexed digit scanner.
module disp_scan
  import disp_pkg::*;
#(
  parameter int unsigned DIV  = 50000,
  parameter int unsigned NDIG = 8,
  parameter bit          LZB  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st,
  input  logic [DIGW*NDIG-1:0] value,
  input  logic                 upd,
  output logic [DIGW-1:0]      num,
  output logic [NDIG-1:0]      dig,
  output logic                 upd_ack
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = $clog2(NDIG);

  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [DIGW*NDIG-1:0]   shadow;
  logic [DIGW*NDIG-1:0]   pend_val;
  logic                   pend;
  logic [NDIG-1:0]        blank;
  logic [MAXDIG*DIGW-1:0] shadow_w;
  logic                   tick;
  logic                   frame_end;
  logic                   load;

  assign tick      = st && (cnt == CW'(DIV - 1));
  assign frame_end = tick && (idx == IW'(NDIG - 1));
  // While dark there is no frame to protect, so a pending value loads at once.
  assign load      = pend && (frame_end || !st);
  assign shadow_w  = (MAXDIG*DIGW)'(shadow);

  disp_lzmask #(
    .NDIG (NDIG),
    .LZB  (LZB)
  ) u_lzmask (
    .shadow (shadow),
    .mask   (blank)
  );

  // Refresh prescaler and scanned digit index; both parked at 0 while dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (!st) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Capture into the pending buffer; swap into shadow only at frame end (or while dark).
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val <= '0;
      pend     <= 1'b0;
      shadow   <= '0;
      upd_ack  <= 1'b0;
    end else begin
      upd_ack <= load;
      if (load) begin
        shadow <= pend_val;
      end
      if (upd) begin
        pend_val <= value;
        pend     <= 1'b1;
      end else if (load) begin
        pend <= 1'b0;
      end
    end
  end

  // Registered digit code and one-hot enable for the current slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      num <= BLANK_CODE;
      dig <= '0;
    end else if (!st || blank[idx]) begin
      num <= BLANK_CODE;
      dig <= '0;
    end else begin
      num <= dig_slice(shadow_w, 32'(idx));
      dig <= NDIG'(1) << idx;
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan: NDIG=8, DIV=4, one instance with LZB=1 and one with LZB=0.
module tb_disp_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        st;
  logic        upd;
  logic [31:0] value;
  logic [3:0]  num, num0;
  logic [7:0]  dig, dig0;
  logic        upd_ack, upd_ack0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  disp_scan #(.DIV(4), .NDIG(8), .LZB(1'b1)) dut (
    .clk(clk), .rst(rst), .st(st), .value(value), .upd(upd),
    .num(num), .dig(dig), .upd_ack(upd_ack)
  );

  disp_scan #(.DIV(4), .NDIG(8), .LZB(1'b0)) dut0 (
    .clk(clk), .rst(rst), .st(st), .value(value), .upd(upd),
    .num(num0), .dig(dig0), .upd_ack(upd_ack0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dark(input string tag);
    check({tag, " dig"},  32'(dig),      32'h0);
    check({tag, " num"},  32'(num),      32'hF);
    check({tag, " ack"},  32'(upd_ack),  32'h0);
    check({tag, " dig0"}, 32'(dig0),     32'h0);
    check({tag, " num0"}, 32'(num0),     32'hF);
    check({tag, " ack0"}, 32'(upd_ack0), 32'h0);
  endtask

  // One 32-cycle frame showing v with nlit lit slots; optional upd at cycles ua/ub.
  task automatic run_frame(input string tag, input logic [31:0] v, input int nlit,
                           input int ua, input logic [31:0] uva,
                           input int ub, input logic [31:0] uvb,
                           input logic ack_end);
    for (int k = 0; k < 32; k++) begin
      int          s;
      logic [3:0]  d;
      logic [31:0] exp_dig;
      logic [31:0] exp_num;
      if (k == ua) begin upd = 1'b1; value = uva; end
      if (k == ub) begin upd = 1'b1; value = uvb; end
      step();
      upd = 1'b0;
      s = k / 4;
      d = v[4*s +: 4];
      exp_dig = (s < nlit) ? (32'd1 << s) : 32'd0;
      exp_num = (s < nlit) ? 32'(d) : 32'hF;
      check($sformatf("%s k%0d dig", tag, k),  32'(dig),      exp_dig);
      check($sformatf("%s k%0d num", tag, k),  32'(num),      exp_num);
      check($sformatf("%s k%0d ack", tag, k),  32'(upd_ack),  32'((k == 31) && ack_end));
      check($sformatf("%s k%0d dig0", tag, k), 32'(dig0),     32'd1 << s);
      check($sformatf("%s k%0d num0", tag, k), 32'(num0),     32'(d));
      check($sformatf("%s k%0d ack0", tag, k), 32'(upd_ack0), 32'((k == 31) && ack_end));
    end
  endtask

  initial begin
    rst = 1'b1; st = 1'b0; upd = 1'b0; value = 32'h0;

    // 1. reset and idle
    step();
    step();
    check_dark("reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_dark($sformatf("idle%0d", i));
    end

    // 2. load while dark, ack on the second edge after upd
    upd = 1'b1; value = 32'h0000_1234;
    step();
    upd = 1'b0;
    check("dark ack edge1", 32'(upd_ack), 32'h0);
    step();
    check("dark ack edge2", 32'(upd_ack), 32'h1);
    check("dark ack0 edge2", 32'(upd_ack0), 32'h1);
    step();
    check_dark("dark after ack");
    st = 1'b1;
    run_frame("f1234a", 32'h0000_1234, 4, -1, 0, -1, 0, 1'b0);
    run_frame("f1234b", 32'h0000_1234, 4, -1, 0, -1, 0, 1'b0);

    // 3. frame-boundary swap
    run_frame("swap", 32'h0000_1234, 4, 10, 32'h99, -1, 0, 1'b1);

    // 4. latest wins, then collision on the load cycle
    run_frame("f99", 32'h99, 2, 5, 32'h5, 12, 32'h7, 1'b1);
    run_frame("f7a", 32'h7, 1, -1, 0, -1, 0, 1'b0);
    run_frame("f7b", 32'h7, 1, 2, 32'h3, 31, 32'h8, 1'b1);
    run_frame("f3", 32'h3, 1, -1, 0, -1, 0, 1'b1);

    // 5. zero value (single lit "0") and LZB=0 view of 5
    run_frame("f8", 32'h8, 1, 0, 32'h0, -1, 0, 1'b1);
    run_frame("f0", 32'h0, 1, 0, 32'h5, -1, 0, 1'b1);
    run_frame("f5", 32'h5, 1, -1, 0, -1, 0, 1'b0);

    // 6. reset during slot 3 with a pending value
    for (int k = 0; k < 13; k++) begin
      if (k == 2) begin upd = 1'b1; value = 32'h42; end
      step();
      upd = 1'b0;
    end
    rst = 1'b1;
    step();
    check_dark("midrst");
    rst = 1'b0; st = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_dark($sformatf("postrst%0d", i));
    end
    st = 1'b1;
    run_frame("restart", 32'h0, 1, -1, 0, -1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
